// File: rtl/digs_to_seg_scan_if.sv
// digs_to_seg_scan_if: digit word, enable and dot requests in; multiplexed anode/segment drive out.
interface digs_to_seg_scan_if;
  logic        en;
  logic [31:0] digs;
  logic [7:0]  dots;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  modport master (output en, digs, dots, input an, seg, dp);
  modport slave  (input en, digs, dots, output an, seg, dp);
endinterface

// File: rtl/digs_to_seg_scan.sv
// digs_to_seg_scan: scans 8 hex nibbles onto a common-anode 7-segment display, one frame-stable snapshot per frame.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module digs_to_seg_scan #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1_000
) (
  input logic clk,
  input logic reset_n,
  digs_to_seg_scan_if.slave bus
);
  localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  if (TICK_DIV < 2) begin : g_bad_div
    $error("digs_to_seg_scan: CLK_HZ/DIGIT_HZ must be at least 2");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_digs_q, snap_digs_d;
  logic [7:0]    snap_dots_q, snap_dots_d;
  logic          primed_q, primed_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick, load, blank_lz;
  logic [31:0]   src_digs;
  logic [7:0]    src_dots;
  logic [3:0]    nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0]    lz;
`endif
  always_comb begin
    tick = bus.en && cnt_q == LAST;
    cnt_d = !bus.en ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    load = (bus.en && !primed_q) || (tick && idx_q == 3'd7);
    snap_digs_d = load ? bus.digs : snap_digs_q;
    snap_dots_d = load ? bus.dots : snap_dots_q;
    primed_d = primed_q || load;
    // the priming cycle displays the word being captured so digit 0 gets its full dwell
    src_digs = primed_q ? snap_digs_q : bus.digs;
    src_dots = primed_q ? snap_dots_q : bus.dots;
    nib = src_digs[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz = '0;
    lz[7] = src_digs[31:28] == 4'd0;
    for (int k = 6; k >= 0; k--) lz[k] = lz[k+1] && src_digs[4*k +: 4] == 4'd0;
    blank_lz = idx_q != 3'd0 && lz[idx_q];
`else
    blank_lz = 1'b0;
`endif
    an_d = bus.en ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d = (!bus.en || blank_lz) ? 7'h7F : HEX[nib];
    dp_d = bus.en ? ~src_dots[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      snap_digs_q <= '0;
      snap_dots_q <= '0;
      primed_q <= 1'b0;
      an_q <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      snap_digs_q <= snap_digs_d;
      snap_dots_q <= snap_dots_d;
      primed_q <= primed_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
endmodule

// File: tb/tb_digs_to_seg_scan.sv
// tb_digs_to_seg_scan: randomized scan stimulus checked by a scoreboard against a frame/dwell arithmetic model.
module tb_digs_to_seg_scan;
  localparam int CLK_HZ = 80, DIGIT_HZ = 10, TD = CLK_HZ / DIGIT_HZ, FR = 8 * TD;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {logic [7:0] an; logic [6:0] seg; logic dp;} out_t;
  localparam out_t BLANK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  digs_to_seg_scan_if bus();
  digs_to_seg_scan #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  out_t exp_q[$];
  int errors = 0, checks = 0;
  int ac = 0;
  logic [31:0] sd = '0;
  logic [7:0]  sp = '0;
  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               name, $time, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
    end
  endtask
  function automatic out_t model_out(input int d);
    out_t o;
    o.an = ~(8'd1 << d);
    o.seg = HEX[sd[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (sd >> (4 * d)) == 32'd0) o.seg = 7'h7F;
`endif
    o.dp = ~sp[d];
    return o;
  endfunction
  // enabled clocks since reset give the dwell position; each frame shows the word seen on its predecessor's last clock
  task automatic step(input logic r, input logic e, input logic [31:0] dg, input logic [7:0] dt);
    @(negedge clk);
    reset_n = r;
    bus.en = e;
    bus.digs = dg;
    bus.dots = dt;
    if (!r) begin
      exp_q.push_back(BLANK);
      ac = 0;
    end else if (!e) exp_q.push_back(BLANK);
    else begin
      if (ac == 0) begin
        sd = dg;
        sp = dt;
      end
      exp_q.push_back(model_out((ac / TD) % 8));
      if (ac % FR == FR - 1) begin
        sd = dg;
        sp = dt;
      end
      ac++;
    end
  endtask
  function automatic logic [31:0] rnd_digs();
    return $urandom >> $urandom_range(0, 31);
  endfunction
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("scan", {bus.an, bus.seg, bus.dp}, exp_q.pop_front());
  end
  initial begin
    logic [31:0] dg;
    logic [7:0] dt;
    bus.en = 1'b0;
    bus.digs = 32'h1234_5678;
    bus.dots = '0;
    #6 check("reset_state", {bus.an, bus.seg, bus.dp}, BLANK);
    repeat (3) step(1'b0, 1'b1, 32'h1234_5678, 8'h00);
    repeat (80) step(1'b1, 1'b1, 32'h1234_5678, 8'h00);
    repeat (70) step(1'b1, 1'b1, 32'hFEDC_BA98, 8'h81);
    for (int i = 0; i < 64 && (ac / TD) % 8 != 3; i++) step(1'b1, 1'b1, 32'hFEDC_BA98, 8'h81);
    repeat (80) step(1'b1, 1'b1, 32'h0000_0000, 8'h00);
    dg = 32'h0000_00A0;
    repeat (70) step(1'b1, 1'b1, dg, 8'h00);
    for (int i = 0; i < 2 * FR && !((ac / TD) % 8 == 5 && ac % TD == 3); i++) step(1'b1, 1'b1, dg, 8'h04);
    repeat (20) step(1'b1, 1'b0, dg, 8'h04);
    repeat (30) step(1'b1, 1'b1, dg, 8'h04);
    for (int i = 0; i < 2 * FR && !((ac / TD) % 8 == 6 && ac % TD == 4); i++) step(1'b1, 1'b1, 32'h8765_4321, 8'h40);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_blank", {bus.an, bus.seg, bus.dp}, BLANK);
    exp_q.push_back(BLANK);
    ac = 0;
    repeat (2) step(1'b0, 1'b1, 32'hCAFE_0042, 8'h11);
    repeat (70) step(1'b1, 1'b1, 32'hCAFE_0042, 8'h11);
    dg = rnd_digs();
    dt = 8'($urandom);
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) dg = rnd_digs();
      if ($urandom_range(0, 15) == 0) dt = 8'($urandom);
      step(1'b1, $urandom_range(0, 9) != 0, dg, dt);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
